// File: rtl/awgn_pkg.sv
// Shared types and defaults for the AWGN noise-path arithmetic blocks.
// Holds the squaring engine FSM encoding and its default operand width.
// Also provides a helper that sizes bit counters for iterative datapaths.
package awgn_pkg;

   // Default operand width of the squaring engine; its result is twice as wide.
   localparam int SQ_IN_W_DEF = 16;

   // Squaring engine control states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } sq_state_t;

   // Width of a counter indexing 0..w-1. It never returns 0, so a
   // one-bit operand still gets a legal one-bit counter.
   function automatic int sq_cnt_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage : awgn_pkg

// File: rtl/square_unit.sv
// Sequential squarer: out_data = in_data * in_data, one shift-add multiplier bit per clock.
// Latency: out_valid rises IN_W cycles after the accept edge. There is no early exit, and only one operand is in flight at a time.
// Backpressure: the result is held in DONE until out_ready. in_ready is high only in IDLE.
module square_unit
   import awgn_pkg::*;
#(
   parameter int IN_W = SQ_IN_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [IN_W-1:0]     in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2*IN_W-1:0]   out_data,
   output logic                busy
);

   localparam int OUT_W = 2 * IN_W;
   localparam int CNT_W = sq_cnt_w(IN_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

   sq_state_t          state_q, state_d;
   logic [IN_W-1:0]    mcand_q, mcand_d;     // multiplicand, fixed for the whole operation
   logic [IN_W-1:0]    mplier_q, mplier_d;   // multiplier, consumed LSB first
   logic [OUT_W-1:0]   acc_q, acc_d;         // running partial-product sum
   logic [CNT_W-1:0]   cnt_q, cnt_d;         // index of the multiplier bit being resolved
   logic [OUT_W-1:0]   out_data_q, out_data_d;

   logic [OUT_W-1:0]   mcand_ext;
   logic [OUT_W-1:0]   addend;
   logic [OUT_W-1:0]   partial;
   logic [OUT_W-1:0]   acc_sum;
   logic               cnt_last;

   // Datapath: weight the multiplicand by the current bit position and add it when that multiplier bit is set.
   // The sum cannot overflow OUT_W bits, because (2^IN_W-1)^2 < 2^OUT_W.
   always_comb begin
      mcand_ext = {{IN_W{1'b0}}, mcand_q};
      addend    = mcand_ext << cnt_q;
      partial   = mplier_q[0] ? addend : '0;
      acc_sum   = acc_q + partial;
      cnt_last  = (cnt_q == CNT_LAST);
   end

   // Next-state and register-update logic for the IDLE -> CALC -> DONE cycle.
   always_comb begin
      state_d    = state_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      out_data_d = out_data_q;

      case (state_q)
         IDLE: begin
            // in_ready is high in IDLE, so in_valid alone completes the handshake.
            if (in_valid) begin
               mcand_d  = in_data;
               mplier_d = in_data;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = CALC;
            end
         end

         CALC: begin
            acc_d    = acc_sum;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            // The last bit's add is folded straight into the published result.
            if (cnt_last) begin
               out_data_d = acc_sum;
               state_d    = DONE;
            end
         end

         DONE: begin
            // out_data_q is untouched here, so the result stays stable under any stall.
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers. A synchronous reset drops any in-flight work and clears every register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         mcand_q    <= '0;
         mplier_q   <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         out_data_q <= out_data_d;
      end
   end

   // Handshake outputs decode from the state register only, so no path runs from in_* to out_*.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q == CALC) || (state_q == DONE);
      out_data  = out_data_q;
   end

endmodule : square_unit

// File: tb/tb_square_unit.sv
// Self-checking bench for square_unit: directed vectors, a mid-operation reset and a random sweep.
// A timing/arithmetic model checks every output on every falling edge.
// The stimulus drives 1 time unit after each rising edge.
module tb_square_unit;

   localparam int IN_W = 16;
   localparam int LAT  = IN_W;

   logic                clk;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [IN_W-1:0]     in_data;
   logic                out_valid;
   logic                out_ready;
   logic [2*IN_W-1:0]   out_data;
   logic                busy;

   int checks;
   int errors;
   int accepts;
   int dut_hs;

   square_unit #(.IN_W(IN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model. An accepted operand produces x*x exactly LAT cycles later.
   // The result is held until out_ready, and nothing is accepted meanwhile.
   bit               model_ok;
   bit               m_busy;
   int               m_age;
   logic [31:0]      m_exp;
   logic [31:0]      m_out;
   int               m_hs;

   always @(posedge clk) begin
      if (rst) begin
         m_busy   <= 1'b0;
         m_age    <= 0;
         m_out    <= '0;
         model_ok <= 1'b1;
      end else if (model_ok) begin
         if (!m_busy) begin
            if (in_valid) begin
               m_busy <= 1'b1;
               m_age  <= 0;
               m_exp  <= {16'b0, in_data} * {16'b0, in_data};
            end
         end else if (m_age < LAT) begin
            m_age <= m_age + 1;
            if (m_age == LAT - 1) m_out <= m_exp;
         end else if (out_ready) begin
            m_busy <= 1'b0;
            m_hs   <= m_hs + 1;
         end
      end
   end

   // The single compare process: runs every cycle once the model has seen a reset.
   always @(negedge clk) begin
      if (model_ok) begin
         chk("in_ready", 64'(in_ready), 64'(!m_busy));
         chk("out_valid", 64'(out_valid), 64'(m_busy && (m_age == LAT)));
         chk("busy", 64'(busy), 64'(m_busy));
         chk("out_data", 64'(out_data), 64'(m_out));
         if (out_valid && out_ready) dut_hs++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present x, wait for in_ready, then take the accept edge.
   task automatic accept(input logic [15:0] x);
      int n;
      in_valid = 1'b1;
      in_data  = x;
      n = 0;
      while (!in_ready && n < 200) begin
         step();
         n++;
      end
      if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      accepts++;
      chk("ready_low_after_accept", 64'(in_ready), 64'd0);
   endtask

   // Wait for out_valid. Check the latency counted from the accept edge, then the result value.
   task automatic wait_res(input logic [31:0] exp, input string name);
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
         step();
         n++;
      end
      chk({name, "_latency"}, 64'(n), 64'(LAT));
      chk({name, "_data"}, 64'(out_data), 64'(exp));
   endtask

   task automatic do_op(input logic [15:0] x, input logic [31:0] exp, input string name);
      out_ready = 1'b1;
      accept(x);
      wait_res(exp, name);
      step();
      chk({name, "_idle_after_hs"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [15:0] x;
      logic [31:0] prod;
      int          base_hs;
      int          base_acc;
      int          n;
      bit          done;

      checks   = 0;
      errors   = 0;
      accepts  = 0;
      dut_hs   = 0;
      model_ok = 1'b0;
      m_busy   = 1'b0;
      m_age    = 0;
      m_out    = '0;
      m_exp    = '0;
      m_hs     = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;

      // 1: reset state
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);

      // 2: a zero operand still takes the full latency
      do_op(16'h0000, 32'h0000_0000, "zero");

      // 3: back-to-back directed operands
      do_op(16'h0003, 32'h0000_0009, "three");
      do_op(16'h00FF, 32'h0000_FE01, "ff");
      do_op(16'h8000, 32'h4000_0000, "msb");

      // 4: full-scale operand with a 10-cycle stall; in_valid pulses are ignored
      out_ready = 1'b0;
      accept(16'hFFFF);
      wait_res(32'hFFFE_0001, "max");
      for (int i = 0; i < 10; i++) begin
         in_valid = (i % 2) == 0;
         in_data  = 16'(i * 7 + 1);
         step();
         chk("stall_data", 64'(out_data), 64'h0000_0000_FFFE_0001);
         chk("stall_valid", 64'(out_valid), 64'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("stall_release_ready", 64'(in_ready), 64'd1);
      chk("stall_release_valid", 64'(out_valid), 64'd0);
      chk("stall_release_hold", 64'(out_data), 64'h0000_0000_FFFE_0001);

      // 5: reset in the middle of CALC discards the operation
      accept(16'h1234);
      repeat (7) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_out_data", 64'(out_data), 64'd0);
      repeat (20) step();
      chk("midrst_still_idle", 64'(out_valid), 64'd0);
      do_op(16'h0010, 32'h0000_0100, "after_rst");

      // 6: random sweep with random acceptance gaps and random out_ready
      base_hs  = dut_hs;
      base_acc = accepts;
      for (int i = 0; i < 1000; i++) begin
         x    = 16'($urandom);
         prod = {16'b0, x} * {16'b0, x};
         repeat ($urandom_range(0, 2)) step();
         out_ready = 1'($urandom_range(0, 1));
         accept(x);
         n    = 0;
         done = 1'b0;
         while (!done && n < 200) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
               chk("sweep_data", 64'(out_data), 64'(prod));
               done = 1'b1;
            end
            step();
            n++;
         end
         if (!done) chk("sweep_timeout", 64'(out_valid), 64'd1);
      end
      out_ready = 1'b1;
      step();
      chk("sweep_result_count", 64'(dut_hs - base_hs), 64'(accepts - base_acc));
      chk("total_hs_vs_model", 64'(dut_hs), 64'(m_hs));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_square_unit

// File: doc/square_unit.md
Name: square_unit

Overview:
Sequential squaring engine for the AWGN noise path. It is the inverse of the square-root stage: it takes an unsigned IN_W-bit magnitude and returns its exact 2*IN_W-bit square. It uses an iterative shift-add datapath that resolves one multiplier bit per clock. Valid/ready handshakes on both sides let it sit between pipeline stages that can stall.

Parameters:
IN_W, 16, operand width in bits; result width is 2*IN_W.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, synchronous and active-high
in_valid  input  1  upstream presents a valid operand on in_data
in_ready  output  1  block can accept an operand this cycle
in_data  input  IN_W  unsigned operand x
out_valid  output  1  out_data holds a completed result
out_ready  input  1  downstream accepts the result this cycle
out_data  output  2*IN_W  unsigned x*x, exact, no saturation or rounding
busy  output  1  high in CALC and DONE states

Behaviour:
- Interface rule: one clock (clk); reset rst is synchronous and active-high.
- Reset, sampled on a clk edge with rst=1, takes priority over everything:
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - out_data, accumulator, operand registers and bit counter all clear to 0.
- Reset mid-operation: any CALC or DONE work is discarded with no output. The first accept is possible on the edge after rst falls.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid & in_ready: mcand <= in_data, mplier <= in_data, acc <= 0, cnt <= 0, go to CALC.
- State CALC (in_ready=0, out_valid=0), each edge:
  - If mplier[0]=1: acc <= acc + (zero-extended mcand << cnt); otherwise acc holds.
  - mplier <= mplier >> 1; cnt <= cnt + 1.
  - On the edge where cnt = IN_W-1, the last add happens: out_data <= final acc, go to DONE.
- Arithmetic widths:
  - acc and addend are 2*IN_W bits.
  - cnt is clog2(IN_W) bits.
  - The sum never overflows, because the max result is (2^IN_W-1)^2 < 2^(2*IN_W).
- State DONE:
  - out_valid=1, in_ready=0.
  - out_data is held stable while out_valid=1 and out_ready=0 (backpressure of any length).
  - On an edge with out_valid & out_ready: go to IDLE, out_valid falls.
- out_data keeps the last result after the handshake and changes only when the next result completes.
- Latency:
  - Accept on edge E0; out_valid is high after edge E0+IN_W (fixed, 16 cycles at default).
  - There is no early termination, so a zero operand also takes the full IN_W cycles.
- Throughput:
  - in_ready is asserted only in IDLE, so there is no overlap between a pending result and a new accept.
  - Minimum spacing is IN_W+2 cycles per operand when out_ready is held at 1.
- in_valid while not in IDLE is ignored; upstream must hold in_data until it sees in_ready.
- in_data changes while in CALC have no effect, because the operand is latched.
- All outputs are registered or decoded from state only, with no combinational path from in_* to out_*.

Decomposition:
- Shared package awgn_pkg holds:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} sq_state_t;
  - localparam SQ_IN_W_DEF = 16.
- No sub-module is needed: the FSM and a single 2*IN_W adder datapath stay in one module.

Test Plan:
1. Assert rst for 3 cycles, then release -> in_ready=1, out_valid=0, busy=0, out_data=0.
2. in_data=0 accepted -> out_valid rises exactly 16 cycles after accept, out_data=0x00000000.
3. Operand sequence 3, 255, 0x8000 with out_ready=1 -> results 9, 0x0000FE01, 0x40000000, each one at 16-cycle latency. in_ready is low between accept and the result handshake.
4. in_data=0xFFFF with out_ready=0 for 10 cycles, then 1 -> out_data=0xFFFE0001 held stable while stalled. Return to IDLE on the handshake edge; in_valid pulses during the stall are ignored.
5. Accept 0x1234, assert rst at cycle 8 of CALC -> no out_valid. Next accept of 0x0010 yields 0x00000100 at the normal latency.
6. Random sweep of 1000 operands with random out_ready gaps -> every out_data equals in_data*in_data. Result count equals accept count.
